// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: PC generation, imem read issue and a small {pc, instr} prefetch FIFO.
// Define FETCH_BYPASS_EN to let a response reach the outputs in its arrival cycle when the queue is empty.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [31:0] OUT_INSTR,
  output logic [31:0] OUT_PC
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          q_empty;
  logic          issue;
  logic          resp;
  logic          bypass_take;
  logic          push;
  logic          pop;

  assign q_empty   = (count == '0);
  // Occupancy ignores a same-cycle pop, so issue can never overrun the queue.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue     = RST_N && !REDIRECT && (occupancy < (CW+1)'(DEPTH));
  assign resp      = inflight && !REDIRECT;

`ifdef FETCH_BYPASS_EN
  assign bypass_take = q_empty && resp && OUT_READY;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = resp && !bypass_take;
  assign pop  = !q_empty && OUT_READY && !REDIRECT;

  assign IMEM_REQ  = issue;
  assign IMEM_ADDR = fetch_pc;

  always_comb begin
    OUT_VALID = !q_empty;
    OUT_INSTR = '0;
    OUT_PC    = '0;
    if (!q_empty) begin
      OUT_INSTR = instr_mem[rd_ptr];
      OUT_PC    = pc_mem[rd_ptr];
    end
`ifdef FETCH_BYPASS_EN
    else if (resp) begin
      OUT_VALID = 1'b1;
      OUT_INSTR = IMEM_RDATA;
      OUT_PC    = inflight_pc;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once counted in.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= IMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue against a queue-based reference model.
// Memory returns addr ^ 32'hA5A5A5A5 one cycle after each request.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        OUT_READY = 1'b0;
  logic        OUT_VALID;
  logic [31:0] OUT_INSTR;
  logic [31:0] OUT_PC;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
    .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_infl;
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_req = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = RST_PC;
    m_ipc    = '0;
    m_infl   = 1'b0;
    mem_pend = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req",   32'(IMEM_REQ),  32'd0);
    chk("rst_addr",  IMEM_ADDR,      RST_PC);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_pc",    OUT_PC,         32'd0);
    chk("rst_instr", OUT_INSTR,      32'd0);
  endtask

  // One clock cycle: entered just after a falling edge, returns at the next falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          e_req;
    bit          e_val;
    bit          byp;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    OUT_READY   = rdy;
    IMEM_RDATA  = mem_pend ? (mem_addr ^ KEY) : $urandom();
    #1;
    e_req = !redir && (q.size() + int'(m_infl) < DEPTH);
    byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (q.size() == 0) && m_infl && !redir;
`endif
    if (q.size() != 0) begin
      e_val = 1'b1; e_pc = q[0].pc; e_instr = q[0].instr;
    end else if (byp) begin
      e_val = 1'b1; e_pc = m_ipc; e_instr = m_ipc ^ KEY;
    end else begin
      e_val = 1'b0; e_pc = '0; e_instr = '0;
    end
    chk("imem_req",  32'(IMEM_REQ),  32'(e_req));
    chk("imem_addr", IMEM_ADDR,      m_pc);
    chk("out_valid", 32'(OUT_VALID), 32'(e_val));
    chk("out_pc",    OUT_PC,         e_pc);
    chk("out_instr", OUT_INSTR,      e_instr);
    mem_pend = IMEM_REQ;
    mem_addr = IMEM_ADDR;
    if (IMEM_REQ) n_req++;
    if (redir) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (m_infl && !(byp && rdy)) q.push_back('{pc: m_ipc, instr: m_ipc ^ KEY});
      m_infl = e_req;
      if (e_req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reset held low for roughly half a cycle, between a rising and the next falling edge.
  task automatic rst_pulse();
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    bit          r_redir;
    logic [31:0] r_pc;
    bit          r_rdy;
    model_reset();
    OUT_READY = 1'b1;
    @(negedge CLK);
    #1 chk_reset_outputs();
    @(negedge CLK);
    RST_N = 1'b1;

    // Free-running stream from reset.
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

    // Stall: exactly DEPTH requests, then drain in order.
    rst_pulse();
    n_req = 0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    chk("stall_reqs", 32'(n_req), 32'(DEPTH));
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Redirect with the queue half full and a request in flight.
    rst_pulse();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_2003, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Redirect in the same cycle as a handshake.
    step(1'b1, 32'h0000_3000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Back-to-back redirects, last one wins.
    step(1'b1, 32'h0000_4000, 1'b1);
    step(1'b1, 32'h0000_5004, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Address wrap.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Random traffic with a mid-stream reset pulse.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst_pulse();
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom();
      r_rdy   = ($urandom_range(0, 3) != 0);
      step(r_redir, r_pc, r_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
